// File: rtl/pmod_i2s_receiver.sv
// pmod_i2s_receiver
// Line-in capture path for the Pmod I2S2 ADC. The externally generated bit
// clock, word select and serial data are oversampled in the clk domain,
// standard I2S frames are deserialised, and each completed left/right pair is
// offered to the record/pitch-detect logic through a valid/ready handshake.

module pmod_i2s_receiver #(
    parameter int WORD_W = 16,
    parameter int SLOT_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              lrclk_in,
    input  logic              sdin,
    input  logic              sample_ready,
    output logic              sample_valid,
    output logic [WORD_W-1:0] left_word,
    output logic [WORD_W-1:0] right_word,
    output logic              overrun,
    output logic              frame_err
);

    typedef enum logic [2:0] {
        SYNC,
        SHIFT_L,
        DISC_L,
        SHIFT_R,
        DISC_R
    } state_t;

    // bitcnt value seen on the edge that carries the last kept data bit
    localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(SLOT_W - 1);

    // synchroniser stages
    logic sclk_meta_q, sclk_meta_d;
    logic sclk_sync_q, sclk_sync_d;
    logic sclk_prev_q, sclk_prev_d;
    logic lrclk_meta_q, lrclk_meta_d;
    logic lrclk_sync_q, lrclk_sync_d;
    logic sdin_meta_q, sdin_meta_d;
    logic sdin_sync_q, sdin_sync_d;

    // bit-level tracking
    logic             lr_last_q, lr_last_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [WORD_W-1:0] left_sr_q, left_sr_d;
    logic [WORD_W-1:0] right_sr_q, right_sr_d;
    logic             pair_done_q, pair_done_d;
    logic             frame_err_q, frame_err_d;

    // output holding registers
    logic              sample_valid_q, sample_valid_d;
    logic [WORD_W-1:0] left_word_q, left_word_d;
    logic [WORD_W-1:0] right_word_q, right_word_d;
    logic              overrun_q, overrun_d;

    logic             bit_edge;
    logic             lr_chg;
    logic [CNT_W-1:0] bitcnt_inc;

    assign bit_edge   = sclk_sync_q & ~sclk_prev_q;
    assign lr_chg     = bit_edge & (lrclk_sync_q != lr_last_q);
    assign bitcnt_inc = (bitcnt_q == CNT_MAX) ? bitcnt_q : bitcnt_q + CNT_W'(1);

    // Two-flop synchronisers for the pins plus the delayed sclk used for edge detection
    always_comb begin
        sclk_meta_d  = sclk_in;
        sclk_sync_d  = sclk_meta_q;
        sclk_prev_d  = sclk_sync_q;
        lrclk_meta_d = lrclk_in;
        lrclk_sync_d = lrclk_meta_q;
        sdin_meta_d  = sdin;
        sdin_sync_d  = sdin_meta_q;
    end

    // Frame tracker: the lrclk-change edge carries the previous word's LSB (I2S delay bit),
    // the following WORD_W edges carry the kept MSB-first bits, the rest of the slot is discarded
    always_comb begin
        lr_last_d   = lr_last_q;
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        left_sr_d   = left_sr_q;
        right_sr_d  = right_sr_q;
        pair_done_d = 1'b0;
        frame_err_d = 1'b0;

        if (bit_edge) begin
            lr_last_d = lrclk_sync_q;
            bitcnt_d  = lr_chg ? '0 : bitcnt_inc;

            case (state_q)
                SYNC: begin
                    if (lr_chg && !lrclk_sync_q) begin
                        state_d = SHIFT_L;
                    end
                end
                SHIFT_L: begin
                    if (lr_chg) begin
                        frame_err_d = 1'b1;
                        state_d     = SYNC;
                    end else begin
                        left_sr_d = {left_sr_q[WORD_W-2:0], sdin_sync_q};
                        if (bitcnt_q == LAST_DATA_CNT) begin
                            state_d = DISC_L;
                        end
                    end
                end
                DISC_L: begin
                    if (lr_chg) begin
                        state_d = lrclk_sync_q ? SHIFT_R : SYNC;
                    end
                end
                SHIFT_R: begin
                    if (lr_chg) begin
                        frame_err_d = 1'b1;
                        state_d     = SYNC;
                    end else begin
                        right_sr_d = {right_sr_q[WORD_W-2:0], sdin_sync_q};
                        if (bitcnt_q == LAST_DATA_CNT) begin
                            pair_done_d = 1'b1;
                            state_d     = DISC_R;
                        end
                    end
                end
                DISC_R: begin
                    if (lr_chg) begin
                        state_d = lrclk_sync_q ? SYNC : SHIFT_L;
                    end
                end
                default: begin
                    state_d = SYNC;
                end
            endcase
        end
    end

    // Output stage: load a completed pair unless an unaccepted pair is still pending
    always_comb begin
        sample_valid_d = sample_valid_q;
        left_word_d    = left_word_q;
        right_word_d   = right_word_q;
        overrun_d      = overrun_q;

        if (pair_done_q) begin
            if (!sample_valid_q || sample_ready) begin
                left_word_d    = left_sr_q;
                right_word_d   = right_sr_q;
                sample_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (sample_valid_q && sample_ready) begin
            sample_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_meta_q    <= 1'b0;
            sclk_sync_q    <= 1'b0;
            sclk_prev_q    <= 1'b0;
            lrclk_meta_q   <= 1'b0;
            lrclk_sync_q   <= 1'b0;
            sdin_meta_q    <= 1'b0;
            sdin_sync_q    <= 1'b0;
            lr_last_q      <= 1'b0;
            state_q        <= SYNC;
            bitcnt_q       <= '0;
            left_sr_q      <= '0;
            right_sr_q     <= '0;
            pair_done_q    <= 1'b0;
            frame_err_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            left_word_q    <= '0;
            right_word_q   <= '0;
            overrun_q      <= 1'b0;
        end else begin
            sclk_meta_q    <= sclk_meta_d;
            sclk_sync_q    <= sclk_sync_d;
            sclk_prev_q    <= sclk_prev_d;
            lrclk_meta_q   <= lrclk_meta_d;
            lrclk_sync_q   <= lrclk_sync_d;
            sdin_meta_q    <= sdin_meta_d;
            sdin_sync_q    <= sdin_sync_d;
            lr_last_q      <= lr_last_d;
            state_q        <= state_d;
            bitcnt_q       <= bitcnt_d;
            left_sr_q      <= left_sr_d;
            right_sr_q     <= right_sr_d;
            pair_done_q    <= pair_done_d;
            frame_err_q    <= frame_err_d;
            sample_valid_q <= sample_valid_d;
            left_word_q    <= left_word_d;
            right_word_q   <= right_word_d;
            overrun_q      <= overrun_d;
        end
    end

    assign sample_valid = sample_valid_q;
    assign left_word    = left_word_q;
    assign right_word   = right_word_q;
    assign overrun      = overrun_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_pmod_i2s_receiver.sv
// tb_pmod_i2s_receiver
// Directed bench for the I2S line-in receiver. sclk runs at clk/8; lrclk and
// sdin change with the falling sclk edge, MSB one sclk after the lrclk change.

module tb_pmod_i2s_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk_in = 1'b0;
    logic        lrclk_in = 1'b0;
    logic        sdin = 1'b0;
    logic        sample_ready = 1'b0;
    logic        sample_valid;
    logic [15:0] left_word;
    logic [15:0] right_word;
    logic        overrun;
    logic        frame_err;

    int          n_checks = 0;
    int          n_fail = 0;
    int          valid_rises = 0;
    int          err_cycles = 0;
    logic        valid_prev = 1'b0;
    logic [15:0] cap_left = '0;
    logic [15:0] cap_right = '0;
    bit          pulse_armed = 1'b0;

    pmod_i2s_receiver #(
        .WORD_W(16),
        .SLOT_W(32),
        .CNT_W (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk_in     (sclk_in),
        .lrclk_in    (lrclk_in),
        .sdin        (sdin),
        .sample_ready(sample_ready),
        .sample_valid(sample_valid),
        .left_word   (left_word),
        .right_word  (right_word),
        .overrun     (overrun),
        .frame_err   (frame_err)
    );

    // 100 MHz-style system clock
    always #5 clk = ~clk;

    // Observe valid rising edges (capturing the pair) and frame_err high cycles
    always @(negedge clk) begin
        if (sample_valid === 1'b1 && valid_prev !== 1'b1) begin
            valid_rises++;
            cap_left  = left_word;
            cap_right = right_word;
        end
        valid_prev = sample_valid;
        if (frame_err === 1'b1) err_cycles++;
    end

    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // One channel slot of nper sclk periods; word bits sent MSB first starting at period 1.
    // ready_bit >= 0 raises sample_ready for exactly the clk in which that bit's pair loads.
    task automatic send_slot(input logic lr, input logic [23:0] word, input int nper, input int ready_bit);
        for (int p = 0; p < nper; p++) begin
            @(negedge clk);
            if (pulse_armed) begin
                sample_ready = 1'b0;
                pulse_armed  = 1'b0;
            end
            sclk_in  = 1'b0;
            lrclk_in = lr;
            sdin     = (p >= 1 && p <= 24) ? word[24-p] : 1'b0;
            repeat (3) @(negedge clk);
            @(negedge clk);
            sclk_in = 1'b1;
            repeat (3) @(negedge clk);
            if (p == ready_bit) begin
                sample_ready = 1'b1;
                pulse_armed  = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int ready_bit);
        send_slot(1'b0, {l, 8'h00}, 32, -1);
        send_slot(1'b1, {r, 8'h00}, 32, ready_bit);
    endtask

    task automatic test_reset();
        rst = 1'b1; sclk_in = 1'b0; lrclk_in = 1'b0; sdin = 1'b0; sample_ready = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b, expected 0", sample_valid); end
        n_checks++; if (left_word !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_left: got %h, expected 0000", left_word); end
        n_checks++; if (right_word !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_right: got %h, expected 0000", right_word); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overrun: got %b, expected 0", overrun); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_err: got %b, expected 0", frame_err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int rises0;
        int errs0;
        sample_ready = 1'b1;
        send_slot(1'b1, 24'h000000, 32, -1);
        send_slot(1'b0, 24'h123456, 10, -1);
        do_reset();
        settle();
        rises0 = valid_rises;
        errs0  = err_cycles;
        n_checks++; if (left_word !== 16'h0000) begin n_fail++; $display("[TB] FAIL midrst_left_cleared: got %h, expected 0000", left_word); end
        send_slot(1'b1, 24'hFFFFFF, 32, -1);
        send_slot(1'b0, {16'h5A5A, 8'h00}, 32, -1);
        settle();
        n_checks++; if (valid_rises - rises0 !== 0) begin n_fail++; $display("[TB] FAIL midrst_no_early_valid: got %0d, expected 0", valid_rises - rises0); end
        n_checks++; if (left_word !== 16'h0000) begin n_fail++; $display("[TB] FAIL midrst_left_still_zero: got %h, expected 0000", left_word); end
        send_slot(1'b1, {16'hC3C3, 8'h00}, 32, -1);
        settle();
        n_checks++; if (valid_rises - rises0 !== 1) begin n_fail++; $display("[TB] FAIL midrst_pair_count: got %0d, expected 1", valid_rises - rises0); end
        n_checks++; if (cap_left !== 16'h5A5A) begin n_fail++; $display("[TB] FAIL midrst_left: got %h, expected 5a5a", cap_left); end
        n_checks++; if (cap_right !== 16'hC3C3) begin n_fail++; $display("[TB] FAIL midrst_right: got %h, expected c3c3", cap_right); end
        n_checks++; if (err_cycles - errs0 !== 0) begin n_fail++; $display("[TB] FAIL midrst_no_frame_err: got %0d, expected 0", err_cycles - errs0); end
    endtask

    task automatic test_basic_frame();
        int rises0;
        int errs0;
        sample_ready = 1'b1;
        rises0 = valid_rises;
        errs0  = err_cycles;
        send_frame(16'h8001, 16'h7FFE, -1);
        settle();
        n_checks++; if (valid_rises - rises0 !== 1) begin n_fail++; $display("[TB] FAIL basic_pair_count: got %0d, expected 1", valid_rises - rises0); end
        n_checks++; if (cap_left !== 16'h8001) begin n_fail++; $display("[TB] FAIL basic_left: got %h, expected 8001", cap_left); end
        n_checks++; if (cap_right !== 16'h7FFE) begin n_fail++; $display("[TB] FAIL basic_right: got %h, expected 7ffe", cap_right); end
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_valid_dropped: got %b, expected 0", sample_valid); end
        n_checks++; if (err_cycles - errs0 !== 0) begin n_fail++; $display("[TB] FAIL basic_no_frame_err: got %0d, expected 0", err_cycles - errs0); end
    endtask

    task automatic test_overrun();
        int rises0;
        sample_ready = 1'b0;
        rises0 = valid_rises;
        send_frame(16'h1111, 16'h2222, -1);
        settle();
        n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ovr_valid_f1: got %b, expected 1", sample_valid); end
        n_checks++; if (left_word !== 16'h1111) begin n_fail++; $display("[TB] FAIL ovr_left_f1: got %h, expected 1111", left_word); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL ovr_clear_f1: got %b, expected 0", overrun); end
        send_frame(16'h3333, 16'h4444, -1);
        settle();
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL ovr_set_f2: got %b, expected 1", overrun); end
        n_checks++; if (left_word !== 16'h1111) begin n_fail++; $display("[TB] FAIL ovr_left_held_f2: got %h, expected 1111", left_word); end
        send_frame(16'h5555, 16'h6666, -1);
        send_frame(16'h7777, 16'h8888, -1);
        settle();
        n_checks++; if (left_word !== 16'h1111) begin n_fail++; $display("[TB] FAIL ovr_left_held_f4: got %h, expected 1111", left_word); end
        n_checks++; if (right_word !== 16'h2222) begin n_fail++; $display("[TB] FAIL ovr_right_held_f4: got %h, expected 2222", right_word); end
        n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ovr_valid_held_f4: got %b, expected 1", sample_valid); end
        n_checks++; if (valid_rises - rises0 !== 1) begin n_fail++; $display("[TB] FAIL ovr_single_valid: got %0d, expected 1", valid_rises - rises0); end
        @(negedge clk); sample_ready = 1'b1;
        @(negedge clk); sample_ready = 1'b0;
        settle();
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ovr_drain_valid: got %b, expected 0", sample_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL ovr_sticky: got %b, expected 1", overrun); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        settle();
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_overrun_reset: got %b, expected 0", overrun); end
        sample_ready = 1'b0;
        send_slot(1'b1, 24'h000000, 32, -1);
        send_frame(16'h0F0F, 16'hF0F0, -1);
        settle();
        n_checks++; if (left_word !== 16'h0F0F) begin n_fail++; $display("[TB] FAIL b2b_left_f1: got %h, expected 0f0f", left_word); end
        send_slot(1'b0, {16'h1357, 8'h00}, 32, -1);
        settle();
        n_checks++; if (right_word !== 16'hF0F0) begin n_fail++; $display("[TB] FAIL b2b_right_f1_held: got %h, expected f0f0", right_word); end
        send_slot(1'b1, {16'h2468, 8'h00}, 32, 16);
        settle();
        n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_valid_stays: got %b, expected 1", sample_valid); end
        n_checks++; if (left_word !== 16'h1357) begin n_fail++; $display("[TB] FAIL b2b_left_f2: got %h, expected 1357", left_word); end
        n_checks++; if (right_word !== 16'h2468) begin n_fail++; $display("[TB] FAIL b2b_right_f2: got %h, expected 2468", right_word); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_no_overrun: got %b, expected 0", overrun); end
        @(negedge clk); sample_ready = 1'b1;
        @(negedge clk); sample_ready = 1'b0;
        settle();
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_drain_valid: got %b, expected 0", sample_valid); end
    endtask

    task automatic test_short_slot();
        int rises0;
        int errs0;
        sample_ready = 1'b1;
        rises0 = valid_rises;
        errs0  = err_cycles;
        send_slot(1'b0, 24'hFFFFFF, 10, -1);
        send_slot(1'b1, {16'h9999, 8'h00}, 32, -1);
        settle();
        n_checks++; if (err_cycles - errs0 !== 1) begin n_fail++; $display("[TB] FAIL short_err_pulse: got %0d cycles, expected 1", err_cycles - errs0); end
        n_checks++; if (valid_rises - rises0 !== 0) begin n_fail++; $display("[TB] FAIL short_no_valid: got %0d, expected 0", valid_rises - rises0); end
        send_frame(16'h4321, 16'h8765, -1);
        settle();
        n_checks++; if (valid_rises - rises0 !== 1) begin n_fail++; $display("[TB] FAIL short_recover_count: got %0d, expected 1", valid_rises - rises0); end
        n_checks++; if (cap_left !== 16'h4321) begin n_fail++; $display("[TB] FAIL short_recover_left: got %h, expected 4321", cap_left); end
        n_checks++; if (cap_right !== 16'h8765) begin n_fail++; $display("[TB] FAIL short_recover_right: got %h, expected 8765", cap_right); end
        n_checks++; if (err_cycles - errs0 !== 1) begin n_fail++; $display("[TB] FAIL short_no_more_err: got %0d, expected 1", err_cycles - errs0); end
    endtask

    task automatic test_mid_right_start();
        int rises0;
        int errs0;
        do_reset();
        sample_ready = 1'b1;
        settle();
        rises0 = valid_rises;
        errs0  = err_cycles;
        send_slot(1'b1, 24'hFFFFFF, 12, -1);
        send_slot(1'b0, 24'hABCDEF, 32, -1);
        send_slot(1'b1, 24'h13579B, 32, -1);
        settle();
        n_checks++; if (valid_rises - rises0 !== 1) begin n_fail++; $display("[TB] FAIL midr_pair_count: got %0d, expected 1", valid_rises - rises0); end
        n_checks++; if (cap_left !== 16'hABCD) begin n_fail++; $display("[TB] FAIL midr_left_trunc: got %h, expected abcd", cap_left); end
        n_checks++; if (cap_right !== 16'h1357) begin n_fail++; $display("[TB] FAIL midr_right_trunc: got %h, expected 1357", cap_right); end
        n_checks++; if (err_cycles - errs0 !== 0) begin n_fail++; $display("[TB] FAIL midr_no_frame_err: got %0d, expected 0", err_cycles - errs0); end
    endtask

    // Scenario sequence
    initial begin
        $display("[TB] starting pmod_i2s_receiver bench");
        test_reset();
        test_reset_mid_frame();
        test_basic_frame();
        test_overrun();
        test_back_to_back();
        test_short_slot();
        test_mid_right_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
